muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide execution unit for the 16-bit datapath.
- Consumes the two register-file read operands (rd1/rd2) plus a destination register address.
- Runs a fixed N-cycle shift-add or restoring-division sequence.
- Produces a one-cycle write-back strobe whose we/addr/data connect directly to the register file write port (we3/wa3/wd3).
- busy stalls the issuing control logic while an operation is in flight.

Parameters:
- n, 16, operand/result bit width.
- r, 3, bit width of register address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin an operation; sampled only when busy=0.
- op  input  2  00 MUL (low n bits of product), 01 MULH (high n bits of product), 10 DIVU (quotient), 11 REMU (remainder).
- a  input  n  operand A (multiplicand / dividend), from register read port 1.
- b  input  n  operand B (multiplier / divisor), from register read port 2.
- rd_addr  input  r  destination register address.
- busy  output  1  high while in RUN or DONE.
- wb_we  output  1  write-back enable to register file, one-cycle pulse.
- wb_addr  output  r  write-back register address.
- wb_data  output  n  write-back data.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, wb_we=0, wb_addr=0, wb_data=0; counter and internal registers cleared.
  - Applies from any state; an in-flight operation is abandoned and no write-back occurs.
- IDLE:
  - start=1 latches a, b, op, rd_addr, loads counter=n and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - One algorithm step per cycle; counter decrements each cycle.
  - When counter reaches 1 at an edge, go to DONE on that edge (exactly n cycles in RUN).
  - start and input changes are ignored in RUN.
- DONE:
  - One cycle; wb_we=1 (subject to the r0 rule), wb_addr=latched rd_addr, wb_data=selected result.
  - Next state IDLE; start is ignored in DONE (busy=1).
- Latency:
  - start sampled at edge t → wb_we high during the cycle after edge t+n+1; next start can be accepted at edge t+n+2.
  - Throughput is one operation per n+2 cycles.
- Multiply: unsigned shift-add on a 2n-bit accumulator; MUL returns product[n-1:0], MULH returns product[2n-1:n].
- Divide: unsigned restoring division, one quotient bit per cycle, with an (n+1)-bit partial remainder.
- Divide by zero (b=0): DIVU result = all ones (0xFFFF); REMU result = a; no exception or flag.
- Destination r0: if rd_addr=0 the operation still runs and DONE still occurs, but wb_we stays 0.
- Outside DONE: wb_we=0, wb_addr and wb_data hold their last driven values (0 after reset).
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then MUL a=0x0123, b=0x0010, rd_addr=3, start at edge t → busy=1 from edge t; wb_we=1, wb_addr=3, wb_data=0x1230 in the single cycle after edge t+17; busy=0 afterwards.
- MUL then MULH with a=0xFFFF, b=0xFFFF → wb_data=0x0001 (MUL) and 0xFFFE (MULH); each takes 18 cycles start-to-idle.
- DIVU and REMU with a=1000, b=7 → wb_data=0x008E (142) and 0x0006; DIVU a=5, b=9 → 0x0000; REMU a=5, b=9 → 0x0005.
- Divide by zero, a=0x1234, b=0 → DIVU wb_data=0xFFFF; REMU wb_data=0x1234; no hang, busy drops on schedule.
- Re-issue start with different operands 5 cycles into a MUL (a=3, b=4) → ignored, result still 0x000C. MUL with rd_addr=0 → DONE cycle occurs, busy timing unchanged, wb_we never asserts.
- Assert rst_n=0 for one cycle at RUN cycle 8 of a DIVU → next cycle busy=0, wb_we=0, wb_data=0; no write-back ever issued for the aborted op. A fresh MUL 2×3 then yields 0x0006.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-division step per cycle,
// finishing with a single registered write-back strobe into the register file.
module muldiv_unit #(
  parameter int n = 16,
  parameter int r = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [r-1:0] rd_addr,
  output logic         busy,
  output logic         wb_we,
  output logic [r-1:0] wb_addr,
  output logic [n-1:0] wb_data
);

  localparam int CW = $clog2(n + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_q;
  logic [r-1:0]   rd_q;
  logic [n-1:0]   a_q;
  logic [n-1:0]   b_q;
  logic [2*n-1:0] prod;
  logic [n:0]     rem;
  logic [n-1:0]   quo;

  logic [n:0]     msum;
  logic [n:0]     dshift;
  logic [n+1:0]   ddiff;
  logic           dge;

  function automatic logic [n-1:0] result_sel(input logic [1:0]     sel,
                                              input logic [2*n-1:0] p,
                                              input logic [n-1:0]   q,
                                              input logic [n:0]     rm);
    case (sel)
      OP_MUL:  result_sel = p[n-1:0];
      OP_MULH: result_sel = p[2*n-1:n];
      OP_DIVU: result_sel = q;
      default: result_sel = rm[n-1:0];
    endcase
  endfunction

  // Low half of prod holds the remaining multiplier bits; the sum carries into the upper half.
  assign msum   = {1'b0, prod[2*n-1:n]} + (prod[0] ? {1'b0, a_q} : {(n+1){1'b0}});
  // A zero divisor always subtracts, giving an all-ones quotient and remainder == dividend.
  assign dshift = {rem[n-1:0], quo[n-1]};
  assign ddiff  = {1'b0, dshift} - {2'b00, b_q};
  assign dge    = ~ddiff[n+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            rd_q  <= rd_addr;
            cnt   <= CW'(n);
            prod  <= {{n{1'b0}}, b};
            rem   <= '0;
            quo   <= a;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          prod <= {msum, prod[n-1:1]};
          rem  <= dge ? ddiff[n:0] : dshift;
          quo  <= {quo[n-2:0], dge};
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          wb_we   <= (rd_q != '0);
          wb_addr <= rd_q;
          wb_data <= result_sel(op_q, prod, quo, rem);
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
